gt_writeback_buffer: RTL and testbench

Write-back buffer between the victim cache and main memory. It accepts dirty 256-bit lines evicted by the victim cache, queues them in a small FIFO, and drains them to main memory one write at a time with a request/acknowledge handshake. Pending lines stay visible to read lookups, so a read that misses the victim cache still returns current data before the line reaches memory. Evictions to a line already queued overwrite that entry in place.

---
 rtl/gt_writeback_buffer.sv | 186 ++++++++++++++++++
 tb/tb_gt_writeback_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gt_writeback_buffer.sv
// gt_writeback_buffer
//   Write-back buffer between the victim cache and main memory. Dirty lines
//   evicted by the victim cache are queued in a small FIFO and drained to
//   memory one write at a time over a request/acknowledge handshake. Queued
//   lines remain visible to read lookups until they are written. An eviction
//   to a line that is already queued (and not currently being written)
//   overwrites that entry in place.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   evictValid/Addr/Data, evictReady   eviction push interface
//   lookupAddr, lookupHit, lookupData  combinational read snoop (one byte)
//   memWrEn/Addr/Data, memAck          memory write request/acknowledge
//   count           number of valid entries
module gt_writeback_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      evictValid,
  input  logic [ADDR_W-1:0]         evictAddr,
  input  logic [LINE_W-1:0]         evictData,
  output logic                      evictReady,
  input  logic [ADDR_W-1:0]         lookupAddr,
  output logic                      lookupHit,
  output logic [7:0]                lookupData,
  output logic                      memWrEn,
  output logic [ADDR_W-1:0]         memWrAddr,
  output logic [LINE_W-1:0]         memWrData,
  input  logic                      memAck,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int TAG_W = ADDR_W - OFF_W;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  // Entry storage. Tags and data are not reset; valid bits gate every use.
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [0:0]        state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [LINE_W-1:0] wr_data_q, wr_data_d;

  logic [TAG_W-1:0]  evict_tag, lookup_tag;
  logic [OFF_W-1:0]  lookup_byte;
  logic [DEPTH-1:0]  evict_match, lookup_match;
  logic              in_flight, coal_hit, full;
  logic              push, do_coal, do_append, pop;
  logic [PTR_W-1:0]  coal_idx, lookup_idx;
  logic [LINE_W-1:0] lookup_line;
  logic              unused_addr_bits;

  assign evict_tag   = evictAddr[ADDR_W-1:OFF_W];
  assign lookup_tag  = lookupAddr[ADDR_W-1:OFF_W];
  assign lookup_byte = lookupAddr[OFF_W-1:0];
  assign unused_addr_bits = ^evictAddr[OFF_W-1:0];

  assign in_flight = (state_q == ST_WRITE);

  // The head entry is excluded from coalescing while it is being written,
  // since the memory has already been handed its data.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign evict_match[gi]  = valid_q[gi] && (tag_q[gi] == evict_tag) &&
                              !(in_flight && (head_q == PTR_W'(gi)));
    assign lookup_match[gi] = valid_q[gi] && (tag_q[gi] == lookup_tag);
  end

  always_comb begin
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (evict_match[i]) coal_idx = PTR_W'(i);
    end
  end

  // Two entries can share a tag only when the head is in flight and a newer
  // copy was appended behind it; a non-head match is therefore the newer one.
  always_comb begin
    lookup_idx = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (lookup_match[i] && (PTR_W'(i) != head_q)) lookup_idx = PTR_W'(i);
    end
  end

  assign coal_hit    = |evict_match;
  assign full        = (count_q == CNT_W'(DEPTH));
  assign evictReady  = !full || coal_hit;
  assign push        = evictValid && evictReady;
  assign do_coal     = push && coal_hit;
  assign do_append   = push && !coal_hit;
  assign pop         = in_flight && memAck;

  assign lookupHit   = |lookup_match;
  assign lookup_line = data_q[lookup_idx] >> {lookup_byte, 3'b000};
  assign lookupData  = lookupHit ? lookup_line[7:0] : 8'h00;

  assign memWrEn   = wr_en_q;
  assign memWrAddr = wr_addr_q;
  assign memWrData = wr_data_q;
  assign count     = count_q;

  always_comb begin
    valid_d   = valid_q;
    head_d    = head_q;
    tail_d    = tail_q;
    state_d   = state_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {tag_q[head_q], {OFF_W{1'b0}}};
          // A coalesce into the head on this same edge must not be lost.
          wr_data_d = (do_coal && (coal_idx == head_q)) ? evictData : data_q[head_q];
          state_d   = ST_WRITE;
        end
      end
      default: begin
        if (memAck) begin
          valid_d[head_q] = 1'b0;
          head_d          = head_q + PTR_W'(1);
          wr_en_d         = 1'b0;
          state_d         = ST_IDLE;
        end
      end
    endcase

    // Append never targets the head while a pop happens: count>0 there, so
    // tail != head unless full, and appends are refused when full.
    if (do_append) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(do_append) - CNT_W'(pop);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      state_q   <= ST_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      valid_q   <= valid_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (do_append) begin
        tag_q[tail_q]  <= evict_tag;
        data_q[tail_q] <= evictData;
      end else if (do_coal) begin
        data_q[coal_idx] <= evictData;
      end
    end
  end

endmodule

// File: tb/tb_gt_writeback_buffer.sv
// Testbench for gt_writeback_buffer: directed stimulus with a scoreboard of
// expected memory writes, checked by an independent monitor.
module tb_gt_writeback_buffer;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         evictValid = 1'b0;
  logic [31:0]  evictAddr = '0;
  logic [255:0] evictData = '0;
  logic         evictReady;
  logic [31:0]  lookupAddr = '0;
  logic         lookupHit;
  logic [7:0]   lookupData;
  logic         memWrEn;
  logic [31:0]  memWrAddr;
  logic [255:0] memWrData;
  logic         memAck = 1'b0;
  logic [2:0]   count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
  } wr_t;
  wr_t exp_q[$];

  gt_writeback_buffer #(.DEPTH(4), .ADDR_W(32), .LINE_W(256)) dut (
    .CLK(CLK), .RST(RST),
    .evictValid(evictValid), .evictAddr(evictAddr), .evictData(evictData),
    .evictReady(evictReady),
    .lookupAddr(lookupAddr), .lookupHit(lookupHit), .lookupData(lookupData),
    .memWrEn(memWrEn), .memWrAddr(memWrAddr), .memWrData(memWrData),
    .memAck(memAck), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] dat(input logic [7:0] b);
    return {32{b}};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [255:0] d, output logic acc);
    evictValid = 1'b1;
    evictAddr  = a;
    evictData  = d;
    #1;
    acc = evictReady;
    step();
    evictValid = 1'b0;
  endtask

  task automatic exp_push(input logic [31:0] a, input logic [255:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Wait (bounded) for a pending write, then acknowledge it for one cycle.
  task automatic ack_one();
    int n = 0;
    while (!memWrEn && n < 50) begin
      step();
      n++;
    end
    if (!memWrEn) begin
      checks++;
      errors++;
      $display("FAIL ack_wait: memWrEn=%0b after %0d cycles, required 1", memWrEn, n);
    end else begin
      memAck = 1'b1;
      step();
      memAck = 1'b0;
    end
  endtask

  // Monitor: an accepted write is memWrEn && memAck held across the next edge.
  always @(negedge CLK) begin
    if (!RST && memWrEn && memAck) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_write_unexpected: got addr %h, required none", memWrAddr);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        $display("mem write addr=%h data=%h", memWrAddr, memWrData[31:0]);
        check("mem_addr", 256'(memWrAddr), 256'(w.addr));
        check("mem_data", memWrData, w.data);
      end
    end
  end

  logic [255:0] d1;
  logic         acc;

  initial begin
    d1 = 256'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666_5555_4444_3333_2222_1111_0000;

    // Reset values
    step();
    step();
    check("rst_memWrEn", 256'(memWrEn), 256'd0);
    check("rst_memWrAddr", 256'(memWrAddr), 256'd0);
    check("rst_count", 256'(count), 256'd0);
    check("rst_lookupHit", 256'(lookupHit), 256'd0);
    check("rst_lookupData", 256'(lookupData), 256'd0);
    check("rst_evictReady", 256'(evictReady), 256'd1);
    RST = 1'b0;
    step();

    // Single line: lookup, write launch, ack
    exp_push(32'h0100_0000, d1);
    push(32'h0100_0000, d1, acc);
    check("t1_accept", 256'(acc), 256'd1);
    lookupAddr = 32'h0100_0003;
    #1;
    check("t1_hit", 256'(lookupHit), 256'd1);
    check("t1_data", 256'(lookupData), 256'h11);
    check("t1_count", 256'(count), 256'd1);
    step();
    check("t1_wren", 256'(memWrEn), 256'd1);
    check("t1_wraddr", 256'(memWrAddr), 256'h0100_0000);
    step();
    step();
    memAck = 1'b1;
    step();
    memAck = 1'b0;
    check("t1_count_after", 256'(count), 256'd0);
    check("t1_hit_after", 256'(lookupHit), 256'd0);
    check("t1_wren_after", 256'(memWrEn), 256'd0);

    // Fill to capacity, refuse fifth, accept after one ack
    for (int k = 1; k <= 4; k++) begin
      exp_push(32'(k) << 24, dat(8'(k)));
      push(32'(k) << 24, dat(8'(k)), acc);
      check("t2_accept", 256'(acc), 256'd1);
    end
    evictAddr = 32'h0500_0005;
    #1;
    check("t2_full_count", 256'(count), 256'd4);
    check("t2_full_ready", 256'(evictReady), 256'd0);
    push(32'h0500_0005, dat(8'h05), acc);
    check("t2_refused", 256'(acc), 256'd0);
    lookupAddr = 32'h0500_0005;
    #1;
    check("t2_count_stays", 256'(count), 256'd4);
    check("t2_absent", 256'(lookupHit), 256'd0);
    ack_one();
    check("t2_count_pop", 256'(count), 256'd3);
    exp_push(32'h0500_0000, dat(8'h05));
    push(32'h0500_0005, dat(8'h05), acc);
    check("t2_accept5", 256'(acc), 256'd1);
    #1;
    check("t2_present", 256'(lookupHit), 256'd1);
    check("t2_present_data", 256'(lookupData), 256'h05);
    for (int k = 0; k < 4; k++) ack_one();
    check("t2_drained", 256'(count), 256'd0);

    // Coalesce behind an in-flight write
    exp_push(32'h0A00_0000, dat(8'hA5));
    push(32'h0A00_0000, dat(8'hA5), acc);
    push(32'h0200_0000, dat(8'hA0), acc);
    check("t3_wren", 256'(memWrEn), 256'd1);
    check("t3_count2", 256'(count), 256'd2);
    exp_push(32'h0200_0000, dat(8'hB0));
    push(32'h0200_0010, dat(8'hB0), acc);
    check("t3_coal_accept", 256'(acc), 256'd1);
    lookupAddr = 32'h0200_0010;
    #1;
    check("t3_count_same", 256'(count), 256'd2);
    check("t3_lookup_new", 256'(lookupData), 256'hB0);
    ack_one();
    ack_one();

    // Matching eviction while that line is in flight appends
    exp_push(32'h0300_0000, dat(8'h30));
    push(32'h0300_0000, dat(8'h30), acc);
    step();
    check("t4_inflight", 256'(memWrEn), 256'd1);
    exp_push(32'h0300_0000, dat(8'h31));
    push(32'h0300_0000, dat(8'h31), acc);
    lookupAddr = 32'h0300_0000;
    #1;
    check("t4_count", 256'(count), 256'd2);
    check("t4_lookup_newer", 256'(lookupData), 256'h31);
    check("t4_wrdata_old", memWrData, dat(8'h30));
    ack_one();
    ack_one();

    // Wrap-around
    for (int i = 0; i < 10; i++) begin
      exp_push(32'(8'h10 + i) << 24, dat(8'(8'h40 + i)));
      push(32'(8'h10 + i) << 24, dat(8'(8'h40 + i)), acc);
      check("t5_count1", 256'(count), 256'd1);
      ack_one();
      check("t5_count0", 256'(count), 256'd0);
    end

    // Reset during a write
    for (int k = 0; k < 3; k++) push(32'(8'h20 + k) << 24, dat(8'(8'h60 + k)), acc);
    lookupAddr = 32'h2100_0000;
    #1;
    check("t6_wren", 256'(memWrEn), 256'd1);
    check("t6_count3", 256'(count), 256'd3);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("t6_wren_rst", 256'(memWrEn), 256'd0);
    check("t6_count_rst", 256'(count), 256'd0);
    check("t6_hit_rst", 256'(lookupHit), 256'd0);
    check("t6_ready_rst", 256'(evictReady), 256'd1);
    memAck = 1'b1;
    step();
    memAck = 1'b0;
    step();
    check("t6_late_ack_wren", 256'(memWrEn), 256'd0);
    check("t6_late_ack_count", 256'(count), 256'd0);

    check("scoreboard_empty", 256'(exp_q.size()), 256'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
